// File: rtl/inst_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetcher: single-outstanding instruction fetch stage feeding the  |
// | decoder; ROB flushes redirect pc and drain in-flight memory requests. |
// | Optional macro IFETCH_PERF_EN adds the _fetch_count handshake counter.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module inst_fetcher (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  input  logic        _mem_ready,
  input  logic [31:0] _mem_data,
  output logic        _inst_ready_out,
  output logic [31:0] _inst_out,
  output logic [31:0] _inst_addr_out,
  input  logic        _dec_stall,
  input  logic [31:0] _next_pc,
  input  logic        _rob_clear,
  input  logic [31:0] _rob_target_pc,
  output logic        _clear_out
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] _fetch_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic        w_handshake;

  // A flush in the same cycle cancels the handshake: the held word is dropped.
  assign w_handshake     = rdy_in && (r_state == HOLD) && !_dec_stall && !_rob_clear;

  assign _mem_req        = (r_state == FETCH);
  assign _mem_addr       = {r_pc[31:2], 2'b00};
  assign _inst_ready_out = (r_state == HOLD);
  assign _inst_out       = r_inst;
  assign _inst_addr_out  = r_inst_addr;
  assign _clear_out      = _rob_clear;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_pc        <= 32'd0;
      r_inst      <= 32'd0;
      r_inst_addr <= 32'd0;
    end else if (rdy_in) begin
      if (_rob_clear) begin
        r_pc <= _rob_target_pc;
        case (r_state)
          IDLE:    r_state <= FETCH;
          // With no response yet, the old request is still in flight and must be drained.
          FETCH:   r_state <= _mem_ready ? FETCH : DRAIN;
          HOLD:    r_state <= FETCH;
          default: r_state <= DRAIN;
        endcase
      end else begin
        case (r_state)
          IDLE: r_state <= FETCH;
          FETCH: begin
            if (_mem_ready) begin
              r_inst      <= _mem_data;
              r_inst_addr <= r_pc;
              r_state     <= HOLD;
            end
          end
          HOLD: begin
            if (w_handshake) begin
              r_pc    <= _next_pc;
              r_state <= FETCH;
            end
          end
          default: begin
            if (_mem_ready) r_state <= FETCH;
          end
        endcase
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)           r_fetch_count <= 32'd0;
    else if (w_handshake) r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign _fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have clk_in  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have rst_in  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have rdy_in  input  1  ready; when low, all state and outputs hold.
REQ-004 SHALL have _mem_req  output  1  instruction-fetch request to memory controller.
REQ-005 SHALL have _mem_addr  output  32  fetch address, pc with bits [1:0] forced to 0.
REQ-006 SHALL have _mem_ready  input  1  one-cycle pulse: _mem_data is valid this cycle.
REQ-007 SHALL have _mem_data  input  32  fetched instruction word.
REQ-008 SHALL have _inst_ready_out  output  1  instruction valid to decoder.
REQ-009 SHALL have _inst_out  output  32  instruction to decoder.
REQ-010 SHALL have _inst_addr_out  output  32  address of _inst_out.
REQ-011 SHALL have _dec_stall  input  1  decoder cannot accept (ROB/RS/LSB full).
REQ-012 SHALL have _next_pc  input  32  decoder-computed successor pc, valid while _inst_ready_out is high.
REQ-013 SHALL have _rob_clear  input  1  mispredict flush pulse from ROB.
REQ-014 SHALL have _rob_target_pc  input  32  redirect pc, valid with _rob_clear.
REQ-015 SHALL have _clear_out  output  1  same-cycle copy of _rob_clear to decoder.

Function
REQ-016 SHALL implement states IDLE, FETCH, HOLD, DRAIN; _mem_req = (state==FETCH); _inst_ready_out = (state==HOLD); _clear_out = _rob_clear combinationally.
REQ-017 SHALL transition IDLE->FETCH unconditionally on the first rdy_in-high edge.
REQ-018 SHALL, in FETCH with _mem_ready high, capture _mem_data into _inst_out, pc into _inst_addr_out, and go to HOLD; minimum request-to-valid latency is one cycle after the _mem_ready cycle.
REQ-019 SHALL hold _mem_addr stable while in FETCH.
REQ-020 SHALL define handshake as _inst_ready_out && !_dec_stall at an edge; on handshake pc <= _next_pc and state -> FETCH.
REQ-021 SHALL keep _inst_out and _inst_addr_out unchanged in HOLD while _dec_stall is high.
REQ-022 SHALL give _rob_clear priority over every other event: pc <= _rob_target_pc in all states.
REQ-023 SHALL, on clear in FETCH without _mem_ready, go to DRAIN; on clear in FETCH with _mem_ready, discard data and go to FETCH.
REQ-024 SHALL, in DRAIN, deassert _mem_req, wait for _mem_ready, discard its data, then go to FETCH; clear in DRAIN updates pc and stays in DRAIN.
REQ-025 SHALL, on clear in HOLD, drop the held instruction (no handshake) and go to FETCH.
REQ-026 SHALL ignore _mem_ready in IDLE and HOLD.
REQ-027 SHALL freeze state, pc and outputs when rdy_in is low, including ignoring _rob_clear and _mem_ready.
REQ-028 SHALL wrap pc arithmetic modulo 2^32, with no alignment traps.

Reset
REQ-029 SHALL, while rst_in is high, force state=IDLE, pc=0, _inst_out=0, _inst_addr_out=0, _mem_req=0, _inst_ready_out=0.
REQ-030 SHALL abandon any outstanding request on reset mid-operation; the memory controller is reset by the same rst_in.

Configuration
REQ-031 SHALL, when IFETCH_PERF_EN is defined, add output _fetch_count (32 bits): count of handshakes, reset 0, wrap at 2^32, unchanged by clear.
REQ-032 SHALL, when IFETCH_PERF_EN is undefined, omit _fetch_count and its counter entirely; all other behaviour is identical.

Verification
REQ-033 SHALL verify: reset release; mem returns 0x00000013 two cycles after request -> _mem_addr=0, then _inst_ready_out=1, _inst_out=0x00000013, _inst_addr_out=0.
REQ-034 SHALL verify: HOLD with _dec_stall=1 for 3 cycles, then 0 and _next_pc=0x8 -> outputs stable for 3 cycles, next _mem_addr=0x8.
REQ-035 SHALL verify: _rob_clear with target 0x100 while FETCH is outstanding -> DRAIN; late _mem_ready data discarded; next _mem_addr=0x100.
REQ-036 SHALL verify: _rob_clear and _mem_ready in the same FETCH cycle -> no _inst_ready_out; next _mem_addr=target.
REQ-037 SHALL verify: rdy_in low for 4 cycles during HOLD with _rob_clear pulsed -> no state or pc change; with IFETCH_PERF_EN, _fetch_count increments exactly once per handshake.
